// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl
//   Session controller for one external Trivium keystream core. It accepts a
//   key/IV/length request and loads the core. It runs the core for WARMUP
//   discarded steps, then steps it one bit per cycle. The bits are packed
//   MSB-first into WORD_W-bit words and presented on a valid/ready stream.
//   The core only steps when this block commands it, so sink backpressure
//   stalls the core and no keystream bit is lost or repeated.
//
// Optional feature: define TRIVIUM_STREAM_CTRL_ABORT_EN to add an `abort`
//   input. abort=1 in LOAD/WARM/GEN/OUT ends the session: the FSM goes to
//   DONE on the next edge, the pending word is dropped, and done still pulses.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   start_valid/ready   request handshake; key, iv, len captured on accept
//   core_load           one-cycle load strobe to the core
//   core_key, core_iv   captured key/IV, stable for the whole session
//   core_step           core advances one bit on this edge
//   core_z              core keystream bit, valid while core_step=1
//   ks_valid/ready      keystream word handshake
//   ks_data             packed word, first bit in the MSB, unused low bits zero
//   ks_nbits            valid bits in ks_data (WORD_W except on the last word)
//   ks_last             final word of the session
//   busy                high in every state except IDLE
//   done                one-cycle pulse at session end
//   abort               (optional) session abort
module trivium_stream_ctrl #(
  parameter int WORD_W = 32,
  parameter int WARMUP = 1152,
  parameter int LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [79:0]               key,
  input  logic [79:0]               iv,
  input  logic [LEN_W-1:0]          len,
  output logic                      core_load,
  output logic [79:0]               core_key,
  output logic [79:0]               core_iv,
  output logic                      core_step,
  input  logic                      core_z,
  output logic                      ks_valid,
  input  logic                      ks_ready,
  output logic [WORD_W-1:0]         ks_data,
  output logic [$clog2(WORD_W):0]   ks_nbits,
  output logic                      ks_last,
  output logic                      busy,
`ifdef TRIVIUM_STREAM_CTRL_ABORT_EN
  output logic                      done,
  input  logic                      abort
`else
  output logic                      done
`endif
);

  localparam int BW   = $clog2(WORD_W);
  localparam int WC_W = $clog2(WARMUP + 1);
  localparam logic [BW:0]     LAST_SLOT = (BW+1)'(WORD_W - 1);
  localparam logic [WC_W-1:0] WARM_INIT = WC_W'(WARMUP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, OUT, DONE} st_t;

  st_t              state, nxt;
  logic [LEN_W-1:0] rem;       // keystream bits still to be generated
  logic [WC_W-1:0]  warm_cnt;  // warm-up steps left minus one
  logic [BW:0]      bit_cnt;   // bits packed into the current word
  logic [WORD_W-1:0] pack;
  logic [BW-1:0]    slot;
  logic             abort_req;

`ifdef TRIVIUM_STREAM_CTRL_ABORT_EN
  assign abort_req = abort & (state inside {LOAD, WARM, GEN, OUT});
`else
  assign abort_req = 1'b0;
`endif

  // WORD_W is a power of two, so WORD_W-1-bit_cnt is the bitwise inverse.
  // Writing by position leaves a partial word left-justified over zeros.
  assign slot     = ~bit_cnt[BW-1:0];
  assign ks_data  = pack;
  assign ks_nbits = bit_cnt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start_valid) nxt = (len == '0) ? DONE : LOAD;
      LOAD: nxt = WARM;
      WARM: if (warm_cnt == '0) nxt = GEN;
      // Close the word when it is full or when this bit is the last one.
      GEN:  if (bit_cnt == LAST_SLOT || rem == LEN_W'(1)) nxt = OUT;
      OUT:  if (ks_ready) nxt = (rem == '0) ? DONE : GEN;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_req) nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rem         <= '0;
      warm_cnt    <= '0;
      bit_cnt     <= '0;
      pack        <= '0;
      core_key    <= '0;
      core_iv     <= '0;
      start_ready <= 1'b1;
      core_load   <= 1'b0;
      core_step   <= 1'b0;
      ks_valid    <= 1'b0;
      ks_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start_valid) begin
          core_key <= key;
          core_iv  <= iv;
          rem      <= len;
        end
        LOAD: warm_cnt <= WARM_INIT;
        WARM: if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
        GEN: begin
          pack[slot] <= core_z;
          bit_cnt    <= bit_cnt + 1'b1;
          rem        <= rem - 1'b1;
          if (nxt == OUT) ks_last <= (rem == LEN_W'(1));
        end
        OUT: if (ks_ready && nxt == GEN) begin
          pack    <= '0;
          bit_cnt <= '0;
        end
        default: ;
      endcase

      // Entering DONE (normally or by abort) drops any pending word so the
      // next session starts from an empty pack register.
      if (nxt == DONE) begin
        pack    <= '0;
        bit_cnt <= '0;
        ks_last <= 1'b0;
      end

      // Outputs are registered as a decode of the next state.
      state       <= nxt;
      start_ready <= (nxt == IDLE);
      core_load   <= (nxt == LOAD);
      core_step   <= (nxt == WARM) || (nxt == GEN);
      ks_valid    <= (nxt == OUT);
      busy        <= (nxt != IDLE);
      done        <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Directed bench for trivium_stream_ctrl. A small behavioural core returns a
// deterministic bit per step index (restarting on core_load), so every packed
// word can be predicted from the step count alone.
module tb_trivium_stream_ctrl;
  localparam int WORD_W = 32;
  localparam int WARMUP = 1152;
  localparam int LEN_W  = 8;   // small enough that the all-ones length is cheap to run

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start_valid = 1'b0;
  logic                    start_ready;
  logic [79:0]             key = '0;
  logic [79:0]             iv = '0;
  logic [LEN_W-1:0]        len = '0;
  logic                    core_load;
  logic [79:0]             core_key;
  logic [79:0]             core_iv;
  logic                    core_step;
  logic                    core_z;
  logic                    ks_valid;
  logic                    ks_ready = 1'b0;
  logic [WORD_W-1:0]       ks_data;
  logic [$clog2(WORD_W):0] ks_nbits;
  logic                    ks_last;
  logic                    busy;
  logic                    done;
`ifdef TRIVIUM_STREAM_CTRL_ABORT_EN
  logic                    abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  trivium_stream_ctrl #(.WORD_W(WORD_W), .WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .key(key), .iv(iv), .len(len),
    .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
    .core_step(core_step), .core_z(core_z),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .ks_nbits(ks_nbits), .ks_last(ks_last),
    .busy(busy),
`ifdef TRIVIUM_STREAM_CTRL_ABORT_EN
    .done(done), .abort(abort)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural core: bit for step k is a fixed hash of k.
  function automatic logic pat(input int k);
    logic [31:0] x;
    x = k * 32'h9E3779B1;
    return x[31] ^ x[19] ^ x[7];
  endfunction

  int zcnt = 0;
  always @(posedge clk)
    if (core_load) zcnt <= 0;
    else if (core_step) zcnt <= zcnt + 1;
  assign core_z = pat(zcnt);

  function automatic logic [WORD_W-1:0] exp_word(input int w, input int nb);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int j = 0; j < nb; j++) r[WORD_W-1-j] = pat(WARMUP + WORD_W*w + j);
    return r;
  endfunction

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int ln;      // requested length
    int stall;   // ks_ready low cycles on the first word
    int nwords;  // expected word count
    int lastnb;  // expected ks_nbits on the last word
  } vec_t;

  // One full session: request, watch every cycle, check words and counts.
  task automatic run_session(input int ln, input int stall, input int nwords, input int lastnb);
    int t, nw, steps, loads, wcyc, hs_t, done_t, unstable, step_out, nbusy, exp_nb, limit;
    bit in_word;
    logic [WORD_W-1:0] held;
    t = 0; nw = 0; steps = 0; loads = 0; wcyc = 0; hs_t = -1; done_t = -1;
    unstable = 0; step_out = 0; nbusy = 0; in_word = 0; held = '0;
    limit = WARMUP + 2*ln + stall + 64;
    @(negedge clk);
    key = {40'h13579BDF02, 32'(ln), 8'h5A};
    iv  = ~key;
    len = LEN_W'(ln);
    start_valid = 1'b1;
    ks_ready = 1'b0;
    check("start_ready", start_ready, 1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("core_key", core_key, key);
    check("core_iv", core_iv, iv);
    while (done_t < 0 && t < limit) begin
      if (core_load) loads++;
      if (core_step) steps++;
      if (!busy) nbusy++;
      if (done) done_t = t;
      if (ks_valid) begin
        if (core_step) step_out++;
        if (!in_word) begin
          if (nw == 0) check("first_valid_latency", t, 1 + WARMUP + (ln < WORD_W ? ln : WORD_W));
          exp_nb = (nw == nwords - 1) ? lastnb : WORD_W;
          check("ks_data", ks_data, exp_word(nw, exp_nb));
          check("ks_nbits", ks_nbits, exp_nb);
          check("ks_last", ks_last, nw == nwords - 1);
          held = ks_data; in_word = 1; wcyc = 0;
        end else if (ks_data !== held) unstable++;
        ks_ready = !(nw == 0 && wcyc < stall);
        wcyc++;
        if (ks_ready) begin hs_t = t; nw++; in_word = 0; end
      end else ks_ready = 1'b0;
      if (done_t < 0) begin @(negedge clk); t++; end
    end
    ks_ready = 1'b0;
    check("done_seen", done_t >= 0, 1);
    check("done_timing", done_t, (ln == 0) ? 0 : hs_t + 1);
    check("word_count", nw, nwords);
    check("load_count", loads, ln > 0);
    check("step_count", steps, (ln == 0) ? 0 : WARMUP + ln);
    check("data_stable", unstable, 0);
    check("step_in_out", step_out, 0);
    check("busy_in_session", nbusy, 0);
    @(negedge clk);
    check("idle_after_done", {start_ready, busy, done}, 3'b100);
  endtask

  initial begin
    vec_t vecs[6];
    int cnt;
    logic [79:0] kept;
    vecs = '{'{0, 0, 0, 0}, '{32, 0, 1, 32}, '{40, 0, 2, 8},
             '{64, 10, 2, 32}, '{1, 0, 1, 1}, '{255, 3, 8, 31}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", {start_ready, busy, done, core_load, core_step, ks_valid, ks_last}, 7'b1000000);
    check("rst_data", ks_data, 0);
    check("rst_nbits", ks_nbits, 0);
    check("rst_key", core_key, 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++)
      run_session(vecs[i].ln, vecs[i].stall, vecs[i].nwords, vecs[i].lastnb);

    // Reset in the middle of warm-up, with an ignored request while busy.
    @(negedge clk);
    key = 80'hDEAD_BEEF_0123_4567_89AB; iv = 80'h1; len = LEN_W'(100);
    kept = key;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (500) @(negedge clk);
    check("warm_ctrl", {busy, start_ready, core_step}, 3'b101);
    key = 80'h1; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    check("busy_ignores_start", core_key, kept);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_reset_ctrl", {start_ready, busy, done, core_step}, 4'b1000);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done | ks_valid | core_step) cnt++; end
    check("mid_reset_quiet", cnt, 0);
    run_session(32, 0, 1, 32);

`ifdef TRIVIUM_STREAM_CTRL_ABORT_EN
    // Abort during the second GEN of a three-word session.
    @(negedge clk);
    len = LEN_W'(96); start_valid = 1'b1; ks_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    cnt = 0;
    while (!ks_valid && cnt < 2000) begin @(negedge clk); cnt++; end
    check("abort_w1_valid", ks_valid, 1);
    check("abort_w1_data", ks_data, exp_word(0, WORD_W));
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_gen", core_step, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_step", core_step, 0);
    check("abort_done", done, 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (ks_valid) cnt++; end
    check("abort_no_valid", cnt, 0);
    check("abort_idle", start_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trivium_stream_ctrl.md
Name: trivium_stream_ctrl

Overview:
Session controller that sequences one Trivium keystream core. It accepts a key/IV/length request over a valid/ready handshake and loads the core. It runs the 4x288-cycle warm-up, then steps the core one bit per cycle and packs the bits into words. Words go to a valid/ready keystream output. The core steps only when the controller commands it, so output backpressure stalls the core.

Parameters:
WORD_W, 32, keystream output word width in bits (power of 2, 8..64)
WARMUP, 1152, core steps discarded after load before the first keystream bit
LEN_W, 16, width of the requested keystream length in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset, sampled on posedge clk
start_valid  in  1  request present
start_ready  out  1  controller can accept a request
key  in  80  session key, captured on accept
iv  in  80  session IV, captured on accept
len  in  LEN_W  keystream length in bits, captured on accept
core_load  out  1  one-cycle load strobe to core
core_key  out  80  captured key, held stable for the whole session
core_iv  out  80  captured IV, held stable for the whole session
core_step  out  1  core advances one bit on this clock edge
core_z  in  1  core keystream bit for the current step, valid whenever core_step=1
ks_valid  out  1  keystream word available
ks_ready  in  1  sink accepts word
ks_data  out  WORD_W  packed keystream, first bit in MSB
ks_nbits  out  log2(WORD_W)+1  number of valid bits in ks_data (WORD_W except for the last word)
ks_last  out  1  marks the final word of the session
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at session end

Behaviour:
- reset=0 at a clock edge returns the FSM to IDLE and clears all counters and the pack register. All outputs then read 0 except start_ready=1.
- A reset during any state aborts the session. No done pulse and no partial word are produced.
- States: IDLE, LOAD, WARM, GEN, OUT, DONE.
- IDLE: start_ready=1. On start_valid&start_ready, capture key, iv and len.
  - len=0: go to DONE. The core is not loaded.
  - len>0: go to LOAD.
- LOAD: core_load=1 and core_step=0 for exactly 1 cycle, then WARM.
- WARM: core_step=1 for exactly WARMUP consecutive cycles. core_z is ignored. Then GEN.
- GEN: core_step=1 each cycle. Each core_z is shifted into the pack register MSB-first. The remaining-bits counter decrements.
  - Leave GEN for OUT after WORD_W bits are packed, or after the bit that brings remaining to 0.
  - A partial word is left-justified with the unused low bits zero.
- OUT: ks_valid=1 and core_step=0. ks_data, ks_nbits and ks_last stay stable until ks_ready.
  - On ks_ready with remaining>0: clear the pack register and go to GEN.
  - On ks_ready with remaining=0: go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. A new request can be accepted on the following cycle.
- Latency from the accepting edge to the first ks_valid = 1+WARMUP+min(len,WORD_W) cycles (1185 with defaults and len>=32).
- Throughput: WORD_W+1 cycles per word with ks_ready held high.
- Word count = ceil(len/WORD_W). ks_nbits = len mod WORD_W on the last word, or WORD_W if that is 0.
- len=2^LEN_W-1 must work; no counter may wrap.
- start_valid is ignored outside IDLE, and start_ready=0 there.

Optional Feature:
Macro: TRIVIUM_STREAM_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any state other than IDLE/DONE forces DONE on the next edge.
  - core_step and ks_valid drop to 0 in that cycle.
  - The pending word is discarded.
  - done pulses as normal.
- Not defined: no abort port; a session always runs to completion.

Test Plan:
- len=0, start_valid 1 cycle -> start accepted, done pulses on the next cycle, core_load and core_step never asserted, ks_valid never asserted.
- len=32, ks_ready=1 -> core_load high 1 cycle, then 1152+32 core_step cycles, and ks_valid exactly 1185 cycles after accept.
  - Expect one word with ks_data equal to the first 32 model keystream bits MSB-first, ks_nbits=32, ks_last=1, and done the cycle after the handshake.
- len=40 -> two words: word 1 with ks_nbits=32 and ks_last=0; word 2 with 8 bits in [31:24], [23:0]=0, ks_nbits=8 and ks_last=1. Total core_step count = 1192.
- len=64 with ks_ready held 0 for 10 cycles on the first word -> core_step=0 and ks_data stable throughout. Second word matches model bits 32..63 (no bits lost or duplicated).
- reset=0 for 1 cycle midway through WARM with len=100 -> next cycle state IDLE, start_ready=1, no done. A new len=32 request then yields the correct first word.
- With TRIVIUM_STREAM_CTRL_ABORT_EN defined, len=96, abort during the second GEN -> core_step=0 next cycle, done pulses, ks_valid not asserted again, and exactly 1 word delivered.
